// File: rtl/toy_pkg.sv
// rtl/toy_pkg.sv - shared types and constants for the toy processor memory stage
package toy_pkg;

    localparam int DATA_W = 8;
    localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/toy_ram_sp.sv
// rtl/toy_ram_sp.sv - single-port synchronous RAM, registered read, no reset
module toy_ram_sp
    import toy_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[ADDR] <= WDATA;
        end
        RDATA <= mem[ADDR];
    end

endmodule

// File: rtl/toy_memory.sv
// rtl/toy_memory.sv - two-phase byte memory, I/O ports and side-band loader
module toy_memory
    import toy_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] IO_ADDR = IO_ADDR_DEFAULT,
    parameter logic [7:0] OUT_RST = 8'h00
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] D_OUT,
    input  logic              MEM_EN,
    input  logic              WRITE_EN,
    output logic [DATA_W-1:0] D_IN,
    output logic              READY,
    input  logic [DATA_W-1:0] IN_PORT,
    output logic [DATA_W-1:0] OUT_PORT,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [DATA_W-1:0] LOAD_DATA,
    output logic              LOAD_ACK
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] d_in_q, d_in_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              rd_pend_q, rd_pend_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic mar_is_io;
    logic load_go;

    assign mar_is_io = (mar_q == IO_ADDR[ADDR_W-1:0]);
    // The loader only owns the RAM port while the processor is fully idle.
    assign load_go   = (state_q == IDLE) && !MEM_EN && LOAD_EN;

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        d_in_d    = d_in_q;
        out_d     = out_q;
        ready_d   = ready_q;
        ack_d     = load_go;
        rd_pend_d = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = mar_q;
        ram_wdata = D_OUT;

        case (state_q)
            IDLE: begin
                if (MEM_EN) begin
                    mar_d   = D_OUT[ADDR_W-1:0];
                    state_d = ADDR;
                end else if (LOAD_EN) begin
                    ram_we    = 1'b1;
                    ram_addr  = LOAD_ADDR;
                    ram_wdata = LOAD_DATA;
                end
            end
            ADDR: begin
                if (!MEM_EN) begin
                    state_d = IDLE;
                end else begin
                    state_d = XFER;
                    if (WRITE_EN) begin
                        if (mar_is_io) begin
                            out_d = D_OUT;
                        end else begin
                            ram_we = 1'b1;
                        end
                    end else if (mar_is_io) begin
                        d_in_d = IN_PORT;
                    end else begin
                        // RAM read data arrives one edge later; capture it in XFER.
                        rd_pend_d = 1'b1;
                    end
                end
            end
            XFER: begin
                ready_d = 1'b1;
                state_d = DONE;
                if (rd_pend_q) begin
                    d_in_d = ram_rdata;
                end
            end
            DONE: begin
                if (!MEM_EN) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            d_in_q    <= '0;
            out_q     <= OUT_RST;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            d_in_q    <= d_in_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    toy_ram_sp #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .CLK  (CLK),
        .WE   (ram_we),
        .ADDR (ram_addr),
        .WDATA(ram_wdata),
        .RDATA(ram_rdata)
    );

    assign D_IN     = d_in_q;
    assign READY    = ready_q;
    assign OUT_PORT = out_q;
    assign LOAD_ACK = ack_q;

endmodule

// File: tb/tb_toy_memory.sv
// tb/tb_toy_memory.sv - directed self-checking bench for toy_memory
module tb_toy_memory;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] D_OUT;
    logic       MEM_EN;
    logic       WRITE_EN;
    logic [7:0] D_IN;
    logic       READY;
    logic [7:0] IN_PORT;
    logic [7:0] OUT_PORT;
    logic       LOAD_EN;
    logic [7:0] LOAD_ADDR;
    logic [7:0] LOAD_DATA;
    logic       LOAD_ACK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rd;

    always #5 CLK = ~CLK;

    toy_memory #(
        .ADDR_W (8),
        .IO_ADDR(8'hFF),
        .OUT_RST(8'h00)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .D_OUT    (D_OUT),
        .MEM_EN   (MEM_EN),
        .WRITE_EN (WRITE_EN),
        .D_IN     (D_IN),
        .READY    (READY),
        .IN_PORT  (IN_PORT),
        .OUT_PORT (OUT_PORT),
        .LOAD_EN  (LOAD_EN),
        .LOAD_ADDR(LOAD_ADDR),
        .LOAD_DATA(LOAD_DATA),
        .LOAD_ACK (LOAD_ACK)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        LOAD_EN = 1'b1; LOAD_ADDR = a; LOAD_DATA = d;
        @(negedge CLK);
        LOAD_EN = 1'b0;
        check("ack_pulse", 8'(LOAD_ACK), 8'h01);
        @(negedge CLK);
        check("ack_low", 8'(LOAD_ACK), 8'h00);
    endtask

    // One full processor access; hold > 0 keeps MEM_EN high in DONE with junk on the bus.
    task automatic do_access(input logic [7:0] a, input logic w, input logic [7:0] wd,
                             input logic collide, input int hold, output logic [7:0] r);
        @(negedge CLK);
        MEM_EN = 1'b1; D_OUT = a; WRITE_EN = w;
        LOAD_EN = collide; LOAD_ADDR = a; LOAD_DATA = 8'hBB;
        @(negedge CLK);
        LOAD_EN = 1'b0; D_OUT = wd;
        check("ack_busy", 8'(LOAD_ACK), 8'h00);
        check("rdy_e0", 8'(READY), 8'h00);
        @(negedge CLK);
        WRITE_EN = ~w;
        check("rdy_e1", 8'(READY), 8'h00);
        @(negedge CLK);
        check("rdy_e2", 8'(READY), 8'h01);
        r = D_IN;
        for (int i = 0; i < hold; i++) begin
            D_OUT = 8'h99; WRITE_EN = 1'b1;
            @(negedge CLK);
            check("hold_rdy", 8'(READY), 8'h01);
            check("hold_din", D_IN, r);
        end
        MEM_EN = 1'b0; WRITE_EN = 1'b0;
        @(negedge CLK);
        check("rdy_drop", 8'(READY), 8'h00);
    endtask

    initial begin
        RESET_N = 1'b0; D_OUT = 8'h00; MEM_EN = 1'b0; WRITE_EN = 1'b0;
        IN_PORT = 8'h00; LOAD_EN = 1'b0; LOAD_ADDR = 8'h00; LOAD_DATA = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_ready", 8'(READY), 8'h00);
        check("rst_din", D_IN, 8'h00);
        check("rst_out", OUT_PORT, 8'h00);
        check("rst_ack", 8'(LOAD_ACK), 8'h00);
        RESET_N = 1'b1;

        load(8'h10, 8'hA5);
        load(8'h11, 8'h3C);
        load(8'h30, 8'h11);
        load(8'h40, 8'h22);
        load(8'hFF, 8'h5A);
        do_access(8'h10, 1'b0, 8'h00, 1'b0, 0, rd);
        check("rd_10", rd, 8'hA5);
        do_access(8'h11, 1'b0, 8'h00, 1'b0, 0, rd);
        check("rd_11", rd, 8'h3C);

        do_access(8'h20, 1'b1, 8'h7E, 1'b0, 0, rd);
        do_access(8'h20, 1'b0, 8'h00, 1'b0, 0, rd);
        check("rd_20", rd, 8'h7E);
        check("out_untouched", OUT_PORT, 8'h00);

        IN_PORT = 8'hC3;
        do_access(8'hFF, 1'b1, 8'h55, 1'b0, 0, rd);
        check("out_io", OUT_PORT, 8'h55);
        check("ram_ff_kept", dut.u_ram.mem[255], 8'h5A);
        do_access(8'hFF, 1'b0, 8'h00, 1'b0, 0, rd);
        check("rd_in_port", rd, 8'hC3);

        // Abort after the address phase: no write to 0x30.
        @(negedge CLK);
        MEM_EN = 1'b1; D_OUT = 8'h30; WRITE_EN = 1'b1;
        @(negedge CLK);
        MEM_EN = 1'b0; D_OUT = 8'hEE;
        @(negedge CLK);
        check("abort_rdy0", 8'(READY), 8'h00);
        @(negedge CLK);
        check("abort_rdy1", 8'(READY), 8'h00);
        WRITE_EN = 1'b0;
        do_access(8'h30, 1'b0, 8'h00, 1'b0, 0, rd);
        check("abort_nowr", rd, 8'h11);

        do_access(8'h40, 1'b0, 8'h00, 1'b1, 0, rd);
        check("collide_rd", rd, 8'h22);
        do_access(8'h40, 1'b0, 8'h00, 1'b0, 0, rd);
        check("collide_nowr", rd, 8'h22);

        // Reset while parked in DONE.
        @(negedge CLK);
        MEM_EN = 1'b1; D_OUT = 8'h11; WRITE_EN = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_rst_rdy", 8'(READY), 8'h01);
        check("pre_rst_din", D_IN, 8'h3C);
        #2 RESET_N = 1'b0;
        #1;
        check("async_rdy", 8'(READY), 8'h00);
        check("async_din", D_IN, 8'h00);
        check("async_out", OUT_PORT, 8'h00);
        @(negedge CLK);
        MEM_EN = 1'b0; RESET_N = 1'b1;
        do_access(8'h10, 1'b0, 8'h00, 1'b0, 0, rd);
        check("post_rst_rd", rd, 8'hA5);

        do_access(8'h10, 1'b0, 8'h00, 1'b0, 5, rd);
        check("hold_rd", rd, 8'hA5);
        do_access(8'h99, 1'b0, 8'h00, 1'b0, 0, rd);
        do_access(8'h10, 1'b0, 8'h00, 1'b0, 0, rd);
        check("hold_noreacc", rd, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/toy_memory.md
Name: toy_memory

Overview:
- Byte-wide data memory and I/O stage for the toy processor; consumes its D_OUT, MEM_EN and WRITE_EN outputs and produces its D_IN input.
- Two-phase bus: the processor presents an address, then a data phase performs the read or write.
- Includes one memory-mapped output register and one input port.
- Includes a side-band loader so a bench can fill memory while the processor is held idle.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W bytes.
- IO_ADDR, 8'hFF, address decoded as I/O instead of RAM.
- OUT_RST, 8'h00, reset value of OUT_PORT.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- D_OUT  in  8  processor output bus; address in the address phase, write data in the data phase.
- MEM_EN  in  1  processor access request; held high for the whole access.
- WRITE_EN  in  1  sampled in the data phase: 1 = write, 0 = read.
- D_IN  out  8  read data to the processor; registered.
- READY  out  1  access complete; D_IN valid for reads.
- IN_PORT  in  8  external input, returned on reads of IO_ADDR.
- OUT_PORT  out  8  register written by stores to IO_ADDR.
- LOAD_EN  in  1  loader write strobe.
- LOAD_ADDR  in  ADDR_W  loader address.
- LOAD_DATA  in  8  loader data.
- LOAD_ACK  out  1  one-cycle pulse: loader write accepted.

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE, MAR=0, D_IN=0, READY=0, OUT_PORT=OUT_RST, LOAD_ACK=0. RAM contents are not cleared.
- FSM states: IDLE, ADDR, XFER, DONE.
- IDLE, MEM_EN=1: MAR<=D_OUT[ADDR_W-1:0]; go to ADDR.
- ADDR, MEM_EN=0: abort to IDLE; no RAM/OUT_PORT side effect.
- ADDR, MEM_EN=1: go to XFER and perform the access:
  - WRITE_EN=1, MAR!=IO_ADDR: mem[MAR]<=D_OUT.
  - WRITE_EN=1, MAR==IO_ADDR: OUT_PORT<=D_OUT; RAM untouched.
  - WRITE_EN=0: D_IN<=(MAR==IO_ADDR) ? IN_PORT : mem[MAR].
- XFER: READY<=1; go to DONE.
- DONE: READY and D_IN held while MEM_EN=1. When MEM_EN=0: READY<=0, go to IDLE. D_IN keeps its last value.
- Latency: MEM_EN rises before edge 0 → MAR latched at edge 0 → access at edge 1 → READY=1 after edge 2. D_IN is valid when READY=1, no later than edge 2.
- WRITE_EN is sampled only in ADDR. Changes after that edge are ignored for the current access.
- Back-to-back accesses need MEM_EN low for at least one cycle (DONE→IDLE). An access held high after DONE never restarts itself.
- Loader:
  - Accepted only when state==IDLE and MEM_EN==0: mem[LOAD_ADDR]<=LOAD_DATA; LOAD_ACK=1 the next cycle.
  - Otherwise ignored, LOAD_ACK=0; the bench must retry.
  - Same cycle as a MEM_EN rise in IDLE: the processor wins and the loader is ignored.
  - A loader write to IO_ADDR writes RAM, not OUT_PORT; that RAM byte is unreachable by processor reads.
- Reset mid-access: returns to IDLE immediately with READY=0. A write already committed at the ADDR→XFER edge stays committed.
- Address wrap: when ADDR_W<8, upper D_OUT bits are ignored. IO_ADDR is compared on the truncated value.

Decomposition:
- Shared package toy_pkg:
  - FSM state enum {IDLE, ADDR, XFER, DONE}.
  - DATA_W=8.
  - Default IO_ADDR constant.
- Sub-module toy_ram_sp: single-port synchronous RAM, parameter ADDR_W, ports CLK/WE/ADDR/WDATA/RDATA, no reset.
  - toy_memory muxes the loader or the processor onto this single port.
  - toy_memory owns the FSM, MAR, OUT_PORT and the IO decode.

Test Plan:
- Loader: LOAD_EN with 8'h10←8'hA5, then 8'h11←8'h3C, both in IDLE → LOAD_ACK pulses once each; processor read of 8'h10 → D_IN=8'hA5, READY high after edge 2.
- Write-then-read: address 8'h20, data 8'h7E, WRITE_EN=1; drop MEM_EN; read 8'h20 → D_IN=8'h7E; OUT_PORT unchanged (8'h00).
- I/O: write 8'h55 to 8'hFF → OUT_PORT=8'h55 and RAM[8'hFF] unchanged; IN_PORT=8'hC3, read 8'hFF → D_IN=8'hC3.
- Abort and collision: MEM_EN high 1 cycle then low → no write, READY stays 0. LOAD_EN in the same cycle as a MEM_EN rise → LOAD_ACK=0 and the loader byte is not written.
- Reset mid-access: RESET_N=0 while in DONE with READY=1 → READY=0, D_IN=0, OUT_PORT=8'h00 asynchronously. After release, the next read of 8'h10 still returns 8'hA5.
- Hold: MEM_EN kept high 5 cycles after READY → READY stays high, D_IN stable, no second access. After MEM_EN drops → READY=0 within 1 cycle.
